// File: rtl/rf_writeback_ctrl.sv
// rf_writeback_ctrl: register-file write port arbiter (ALU priority, queued LSU) with pending-load scoreboard
module rf_writeback_ctrl #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     alu_valid_i,
    input  logic [4:0]               alu_rd_i,
    input  logic [XLEN-1:0]          alu_data_i,
    input  logic                     lsu_valid_i,
    output logic                     lsu_ready_o,
    input  logic [4:0]               lsu_rd_i,
    input  logic [XLEN-1:0]          lsu_data_i,
    input  logic                     load_issue_i,
    input  logic [4:0]               load_issue_rd_i,
    output logic                     reg_write_en_o,
    output logic [4:0]               rd_addr_o,
    output logic [XLEN-1:0]          rd_data_o,
    output logic [31:0]              busy_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [XLEN-1:0] data_mem [DEPTH];
    logic [4:0]      rd_mem   [DEPTH];
    logic [AW-1:0]   wptr, rptr;
    logic [CW-1:0]   count;
    logic            alu_w, acc_nz, pop, bypass, push, wb_lsu;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [31:0]     busy_set, busy_clr;
    assign lsu_ready_o  = count != CW'(DEPTH);
    assign fifo_count_o = count;
    always_comb begin
        alu_w    = alu_valid_i && alu_rd_i != 5'd0;
        acc_nz   = lsu_valid_i && lsu_ready_o && lsu_rd_i != 5'd0;
        pop      = !alu_w && count != '0;
        bypass   = !alu_w && count == '0 && acc_nz;
        push     = acc_nz && !bypass;
        wb_lsu   = pop || bypass;
        wb_rd    = pop ? rd_mem[rptr] : lsu_rd_i;
        wb_data  = pop ? data_mem[rptr] : lsu_data_i;
        busy_clr = wb_lsu ? 32'd1 << wb_rd : 32'd0;
        busy_set = (load_issue_i && load_issue_rd_i != 5'd0) ? 32'd1 << load_issue_rd_i : 32'd0;
    end
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem[wptr] <= lsu_data_i;
            rd_mem[wptr]   <= lsu_rd_i;
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr           <= '0;
            rptr           <= '0;
            count          <= '0;
            reg_write_en_o <= 1'b0;
            rd_addr_o      <= '0;
            rd_data_o      <= '0;
            busy_o         <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            count          <= count + CW'(push) - CW'(pop);
            reg_write_en_o <= alu_w || wb_lsu;
            if (alu_w) begin
                rd_addr_o <= alu_rd_i;
                rd_data_o <= alu_data_i;
            end else if (wb_lsu) begin
                rd_addr_o <= wb_rd;
                rd_data_o <= wb_data;
            end
            busy_o <= ((busy_o & ~busy_clr) | busy_set) & ~32'd1;
        end
    end
endmodule
